// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet/IPv4 header extractor.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [3:0]  IPV4_VERSION   = 4'd4;

  // Byte offsets of header fields from the first byte of the frame.
  localparam int OFF_DST    = 0;
  localparam int OFF_SRC    = 6;
  localparam int OFF_ETYPE  = 12;
  localparam int OFF_VER    = 14;
  localparam int OFF_PROTO  = 23;
  localparam int OFF_IP_SRC = 26;
  localparam int OFF_IP_DST = 30;

  localparam int BEAT_BYTES   = 8;
  localparam int MIN_ETH_LEN  = 14;  // shorter frames are runts
  localparam int IPV4_MIN_LEN = 34;  // must reach byte 33 (end of dst IP)
  localparam logic [2:0] HDR_LAST_BEAT = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY} state_e;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [5:0]  error;
  } beat_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        is_ipv4;
    logic [7:0]  ip_proto;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic        runt;
  } meta_t;

  // MSB position inside a 64-bit beat of the byte at frame offset 'off'.
  function automatic int byte_msb(int off);
    return 63 - 8 * (off % BEAT_BYTES);
  endfunction

endpackage

// File: rtl/avalon_st_reg_slice.sv
// Single-stage Avalon-ST register slice with full-throughput ready rule.
module avalon_st_reg_slice
  import eth_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  beat_t in_beat,
  input  logic  in_valid,
  output logic  in_ready,
  output beat_t out_beat,
  output logic  out_valid,
  input  logic  out_ready
);

  beat_t beat_q, beat_d;
  logic  valid_q, valid_d;

  // Load on accept; drop valid once downstream has taken the held beat.
  always_comb begin
    in_ready = out_ready | ~valid_q;
    beat_d   = beat_q;
    valid_d  = valid_q;
    if (in_valid && in_ready) begin
      beat_d  = in_beat;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slice register.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign out_beat  = beat_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/eth_hdr_extract.sv
// Forwards a 64-bit Avalon-ST frame stream through a register slice while
// extracting Ethernet II / IPv4 header fields and keeping frame statistics.
module eth_hdr_extract
  import eth_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      asi_in_data,
  input  logic             asi_in_valid,
  input  logic             asi_in_sop,
  input  logic             asi_in_eop,
  input  logic [2:0]       asi_in_empty,
  input  logic [5:0]       asi_in_error,
  output logic             asi_in_ready,
  output logic [63:0]      aso_out_data,
  output logic             aso_out_valid,
  output logic             aso_out_sop,
  output logic             aso_out_eop,
  output logic [2:0]       aso_out_empty,
  output logic [5:0]       aso_out_error,
  input  logic             aso_out_ready,
  output logic             meta_valid,
  output logic [47:0]      meta_dst_mac,
  output logic [47:0]      meta_src_mac,
  output logic [15:0]      meta_ethertype,
  output logic             meta_is_ipv4,
  output logic [7:0]       meta_ip_proto,
  output logic [31:0]      meta_ip_src,
  output logic [31:0]      meta_ip_dst,
  output logic             meta_runt,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] byte_count,
  output logic [ERR_W-1:0] err_count
);

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    logic [3:0]  ver;
    logic [7:0]  proto;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
  } hdr_t;

  beat_t in_beat, out_beat;

  assign in_beat = '{data: asi_in_data, sop: asi_in_sop, eop: asi_in_eop,
                     empty: asi_in_empty, error: asi_in_error};

  avalon_st_reg_slice u_slice (
    .clk       (clk),
    .reset     (reset),
    .in_beat   (in_beat),
    .in_valid  (asi_in_valid),
    .in_ready  (asi_in_ready),
    .out_beat  (out_beat),
    .out_valid (aso_out_valid),
    .out_ready (aso_out_ready)
  );

  assign aso_out_data  = out_beat.data;
  assign aso_out_sop   = out_beat.sop;
  assign aso_out_eop   = out_beat.eop;
  assign aso_out_empty = out_beat.empty;
  assign aso_out_error = out_beat.error;

  state_e           state_q, state_d;
  logic [2:0]       bidx_q, bidx_d;
  hdr_t             hdr_q, hdr_d;
  logic [CNT_W-1:0] len_q, len_d;
  meta_t            meta_q, meta_d;
  logic             meta_valid_q, meta_valid_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             acc, opened, hdr_beat, is4;
  logic [2:0]       cur_idx;
  logic [1:0]       err_inc;
  logic [CNT_W-1:0] beat_end, flen;
  logic [ERR_W:0]   err_sum;

  // Parser FSM, header capture, metadata emission and counter updates.
  // If a sop+eop beat closes an abandoned header in the same cycle, the new
  // one-beat frame's record takes the single metadata pulse.
  always_comb begin
    state_d      = state_q;
    bidx_d       = bidx_q;
    hdr_d        = hdr_q;
    len_d        = len_q;
    meta_d       = meta_q;
    meta_valid_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    err_inc      = 2'd0;
    is4          = 1'b0;

    acc      = asi_in_valid & asi_in_ready;
    opened   = asi_in_sop | (state_q != S_IDLE);
    hdr_beat = asi_in_sop | (state_q == S_HDR);
    cur_idx  = asi_in_sop ? 3'd0 : bidx_q;
    beat_end = (asi_in_sop ? '0 : len_q) + CNT_W'(BEAT_BYTES);
    flen     = beat_end - CNT_W'(asi_in_empty);

    if (acc) begin
      len_d = beat_end;

      if (!opened) err_inc = err_inc + 2'd1;

      if (asi_in_sop && state_q != S_IDLE) begin
        err_inc = err_inc + 2'd1;
        if (state_q == S_HDR) begin
          meta_d           = '0;
          meta_d.dst_mac   = hdr_q.dst;
          meta_d.src_mac   = hdr_q.src;
          meta_d.ethertype = hdr_q.etype;
          meta_valid_d     = 1'b1;
        end
      end

      if (hdr_beat) begin
        if (asi_in_sop) hdr_d = '0;
        case (cur_idx)
          3'd0: begin
            hdr_d.dst         = asi_in_data[byte_msb(OFF_DST) -: 48];
            hdr_d.src[47:32]  = asi_in_data[byte_msb(OFF_SRC) -: 16];
          end
          3'd1: begin
            hdr_d.src[31:0]   = asi_in_data[byte_msb(OFF_SRC + 2) -: 32];
            hdr_d.etype       = asi_in_data[byte_msb(OFF_ETYPE) -: 16];
            hdr_d.ver         = asi_in_data[byte_msb(OFF_VER) -: 4];
          end
          3'd2: hdr_d.proto   = asi_in_data[byte_msb(OFF_PROTO) -: 8];
          3'd3: begin
            hdr_d.ip_src        = asi_in_data[byte_msb(OFF_IP_SRC) -: 32];
            hdr_d.ip_dst[31:16] = asi_in_data[byte_msb(OFF_IP_DST) -: 16];
          end
          3'd4: hdr_d.ip_dst[15:0] = asi_in_data[byte_msb(OFF_IP_DST + 2) -: 16];
          default: ;
        endcase

        if (cur_idx == HDR_LAST_BEAT || asi_in_eop) begin
          is4 = (hdr_d.etype == ETHERTYPE_IPV4) && (hdr_d.ver == IPV4_VERSION) &&
                (cur_idx == HDR_LAST_BEAT) &&
                (!asi_in_eop || flen >= CNT_W'(IPV4_MIN_LEN));
          meta_d.dst_mac   = hdr_d.dst;
          meta_d.src_mac   = hdr_d.src;
          meta_d.ethertype = hdr_d.etype;
          meta_d.is_ipv4   = is4;
          meta_d.ip_proto  = is4 ? hdr_d.proto  : 8'd0;
          meta_d.ip_src    = is4 ? hdr_d.ip_src : 32'd0;
          meta_d.ip_dst    = is4 ? hdr_d.ip_dst : 32'd0;
          meta_d.runt      = asi_in_eop && (flen < CNT_W'(MIN_ETH_LEN));
          meta_valid_d     = 1'b1;
          state_d          = asi_in_eop ? S_IDLE : S_BODY;
        end else begin
          state_d = S_HDR;
          bidx_d  = cur_idx + 3'd1;
        end
      end else if (state_q == S_BODY && asi_in_eop) begin
        state_d = S_IDLE;
      end

      if (opened && asi_in_eop) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        byte_cnt_d  = byte_cnt_q + flen;
        if (asi_in_error != 6'd0) err_inc = err_inc + 2'd1;
      end
    end

    err_sum   = {1'b0, err_cnt_q} + (ERR_W+1)'(err_inc);
    err_cnt_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
  end

  // Parser and statistics state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bidx_q       <= 3'd0;
      hdr_q        <= '0;
      len_q        <= '0;
      meta_q       <= '0;
      meta_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
      byte_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bidx_q       <= bidx_d;
      hdr_q        <= hdr_d;
      len_q        <= len_d;
      meta_q       <= meta_d;
      meta_valid_q <= meta_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign meta_valid     = meta_valid_q;
  assign meta_dst_mac   = meta_q.dst_mac;
  assign meta_src_mac   = meta_q.src_mac;
  assign meta_ethertype = meta_q.ethertype;
  assign meta_is_ipv4   = meta_q.is_ipv4;
  assign meta_ip_proto  = meta_q.ip_proto;
  assign meta_ip_src    = meta_q.ip_src;
  assign meta_ip_dst    = meta_q.ip_dst;
  assign meta_runt      = meta_q.runt;
  assign frame_count    = frame_cnt_q;
  assign byte_count     = byte_cnt_q;
  assign err_count      = err_cnt_q;

endmodule
